// File: rtl/ulpb_rx_responder_if.sv
// Signal bundle for the ULPB receive responder: node handshake side and
// consumer message side.
interface ulpb_rx_responder_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] rx_addr;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_req;
    logic                  rx_pend;
    logic                  rx_fail;
    logic                  rx_ack;
    logic [ADDR_WIDTH-1:0] msg_addr;
    logic [DATA_WIDTH-1:0] msg_data;
    logic                  msg_last;
    logic                  msg_valid;
    logic                  msg_pop;
    logic                  msg_drop;
    logic                  overflow;
    logic                  ovf_clr;

    modport master (
        output rx_addr, rx_data, rx_req, rx_pend, rx_fail,
        output msg_pop, ovf_clr,
        input  rx_ack, msg_addr, msg_data, msg_last,
        input  msg_valid, msg_drop, overflow
    );

    modport slave (
        input  rx_addr, rx_data, rx_req, rx_pend, rx_fail,
        input  msg_pop, ovf_clr,
        output rx_ack, msg_addr, msg_data, msg_last,
        output msg_valid, msg_drop, overflow
    );
endinterface

// File: rtl/ulpb_rx_responder.sv
// ULPB receive responder: 4-phase word handshake into a message buffer
// that only exposes words once their whole message has arrived.
module ulpb_rx_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic [ADDR_WIDTH-1:0] RX_ADDR,
    input  logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic                  RX_REQ,
    input  logic                  RX_PEND,
    input  logic                  RX_FAIL,
    output logic                  RX_ACK,
    output logic [ADDR_WIDTH-1:0] MSG_ADDR,
    output logic [DATA_WIDTH-1:0] MSG_DATA,
    output logic                  MSG_LAST,
    output logic                  MSG_VALID,
    input  logic                  MSG_POP,
    output logic                  MSG_DROP,
    output logic                  OVERFLOW,
    input  logic                  OVF_CLR
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    typedef enum logic [2:0] {
        IDLE, STALL, ACK, FAIL_ACK, DISCARD
    } state_t;

    state_t state_q, state_d;

    logic [1:0]    req_sync_q, fail_sync_q;
    logic          req_s, fail_s;
    logic [PW-1:0] wr_q, wr_d, cm_q, cm_d, rd_q, rd_d;
    logic [PW-1:0] used, unc;
    logic          has_free, unc_full;
    logic          ack_q, ack_d, drop_q, drop_d;
    logic          ovf_q, ovf_d, disc_q, disc_d;
    logic          last_q, last_d;
    logic          push, rollback, ovf_set, pop;

    logic [ADDR_WIDTH-1:0] mem_a [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  mem_l [DEPTH];

    assign req_s    = req_sync_q[1];
    assign fail_s   = fail_sync_q[1];
    assign used     = wr_q - rd_q;
    assign unc      = wr_q - cm_q;
    assign has_free = used < PW'(DEPTH);
    assign unc_full = unc == PW'(DEPTH);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fail_s)          state_d = FAIL_ACK;
                else if (req_s) begin
                    if (has_free)       state_d = ACK;
                    else if (!unc_full) state_d = STALL;
                    else                state_d = DISCARD;
                end
            end
            STALL: begin
                if (fail_s)        state_d = FAIL_ACK;
                else if (has_free) state_d = ACK;
            end
            // a discarded word returns to DISCARD unless it ended the message
            ACK: begin
                if (!req_s)
                    state_d = (disc_q && !last_q) ? DISCARD : IDLE;
            end
            FAIL_ACK: if (!fail_s) state_d = IDLE;
            DISCARD: begin
                if (fail_s)     state_d = FAIL_ACK;
                else if (req_s) state_d = ACK;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        push     = 1'b0;
        rollback = 1'b0;
        ovf_set  = 1'b0;
        drop_d   = 1'b0;
        disc_d   = disc_q;
        last_d   = last_q;
        unique case (state_q)
            IDLE, STALL: begin
                push = (state_d == ACK);
                if (state_d == DISCARD) begin
                    ovf_set  = 1'b1;
                    rollback = 1'b1;
                    disc_d   = 1'b1;
                end
            end
            ACK: begin
                if (state_d == IDLE && disc_q) begin
                    drop_d = 1'b1;
                    disc_d = 1'b0;
                end
            end
            DISCARD: if (state_d == ACK) last_d = ~RX_PEND;
            default: ;
        endcase
        if (state_d == FAIL_ACK && state_q != FAIL_ACK) begin
            rollback = 1'b1;
            drop_d   = (unc != '0);
            disc_d   = 1'b0;
        end
        ack_d = (state_d == ACK) || (state_d == FAIL_ACK);
        ovf_d = ovf_set || (ovf_q && !OVF_CLR);
    end

    assign pop = MSG_POP && (cm_q != rd_q);

    always_comb begin
        wr_d = wr_q;
        cm_d = cm_q;
        rd_d = rd_q;
        if (push) begin
            wr_d = wr_q + 1'b1;
            if (!RX_PEND) cm_d = wr_q + 1'b1;
        end
        if (rollback) wr_d = cm_q;
        if (pop)      rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            req_sync_q  <= '0;
            fail_sync_q <= '0;
            wr_q        <= '0;
            cm_q        <= '0;
            rd_q        <= '0;
            ack_q       <= 1'b0;
            drop_q      <= 1'b0;
            ovf_q       <= 1'b0;
            disc_q      <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            req_sync_q  <= {req_sync_q[0], RX_REQ};
            fail_sync_q <= {fail_sync_q[0], RX_FAIL};
            wr_q        <= wr_d;
            cm_q        <= cm_d;
            rd_q        <= rd_d;
            ack_q       <= ack_d;
            drop_q      <= drop_d;
            ovf_q       <= ovf_d;
            disc_q      <= disc_d;
            last_q      <= last_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_a[wr_q[IW-1:0]] <= RX_ADDR;
            mem_d[wr_q[IW-1:0]] <= RX_DATA;
            mem_l[wr_q[IW-1:0]] <= ~RX_PEND;
        end
    end

    assign RX_ACK    = ack_q;
    assign MSG_DROP  = drop_q;
    assign OVERFLOW  = ovf_q;
    assign MSG_VALID = (cm_q != rd_q);
    assign MSG_ADDR  = mem_a[rd_q[IW-1:0]];
    assign MSG_DATA  = mem_d[rd_q[IW-1:0]];
    assign MSG_LAST  = mem_l[rd_q[IW-1:0]];
endmodule

// File: tb/tb_ulpb_rx_responder.sv
// Bench for ulpb_rx_responder: directed handshakes against a queue model
// of committed and in-flight message words.
module tb_ulpb_rx_responder;
    localparam int D = 8;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
        logic        l;
    } w_t;

    logic CLK = 1'b0;
    logic RESETn = 1'b0;

    ulpb_rx_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    ulpb_rx_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(D)) dut (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .RX_ADDR  (bus.rx_addr),
        .RX_DATA  (bus.rx_data),
        .RX_REQ   (bus.rx_req),
        .RX_PEND  (bus.rx_pend),
        .RX_FAIL  (bus.rx_fail),
        .RX_ACK   (bus.rx_ack),
        .MSG_ADDR (bus.msg_addr),
        .MSG_DATA (bus.msg_data),
        .MSG_LAST (bus.msg_last),
        .MSG_VALID(bus.msg_valid),
        .MSG_POP  (bus.msg_pop),
        .MSG_DROP (bus.msg_drop),
        .OVERFLOW (bus.overflow),
        .OVF_CLR  (bus.ovf_clr)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int drop_cnt = 0;

    w_t   cq[$];
    w_t   pq[$];
    logic exp_drop = 0;
    logic exp_ovf = 0;
    logic disc = 0;
    logic disc_last = 0;
    logic ack_prev = 0;
    logic busy = 0;
    logic chk_en = 0;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        cq.delete();
        pq.delete();
        exp_drop  = 0;
        exp_ovf   = 0;
        disc      = 0;
        disc_last = 0;
        ack_prev  = 0;
    endtask

    // Advance one clock and apply to the model whatever that edge did.
    task automatic cyc();
        w_t w;
        @(posedge CLK);
        #1;
        exp_drop = 0;
        if (bus.ovf_clr) exp_ovf = 0;
        if (bus.msg_pop && cq.size() > 0) void'(cq.pop_front());
        if (bus.rx_ack && !ack_prev) begin
            if (bus.rx_fail) begin
                if (pq.size() > 0) exp_drop = 1;
                pq.delete();
                disc = 0;
                disc_last = 0;
            end else if (disc) begin
                if (!bus.rx_pend) disc_last = 1;
            end else if (pq.size() == D) begin
                exp_ovf = 1;
                pq.delete();
                disc = 1;
                if (!bus.rx_pend) disc_last = 1;
            end else begin
                w.a = bus.rx_addr;
                w.d = bus.rx_data;
                w.l = ~bus.rx_pend;
                pq.push_back(w);
                if (w.l) begin
                    foreach (pq[i]) cq.push_back(pq[i]);
                    pq.delete();
                end
            end
        end
        if (!bus.rx_ack && ack_prev && disc_last) begin
            exp_drop  = 1;
            disc_last = 0;
            disc      = 0;
        end
        ack_prev = bus.rx_ack;
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("valid", bus.msg_valid, cq.size() != 0);
            if (bus.msg_valid && cq.size() > 0) begin
                chk("head_addr", bus.msg_addr, cq[0].a);
                chk("head_data", bus.msg_data, cq[0].d);
                chk("head_last", bus.msg_last, cq[0].l);
            end
            chk("drop", bus.msg_drop, exp_drop);
            if (!busy || bus.rx_ack) chk("ovf", bus.overflow, exp_ovf);
            if (bus.msg_drop) drop_cnt++;
        end
    end

    task automatic wait_ack(input logic v, output int n);
        n = 0;
        while (bus.rx_ack !== v && n < 100) begin
            cyc();
            n++;
        end
        chk("ack_wait", bus.rx_ack, v);
    endtask

    task automatic send(input logic [7:0] a, input logic [31:0] d,
                        input logic pend, output int nr, output int nf);
        bus.rx_addr = a;
        bus.rx_data = d;
        bus.rx_pend = pend;
        bus.rx_req  = 1;
        busy = 1;
        wait_ack(1, nr);
        bus.rx_req = 0;
        wait_ack(0, nf);
        busy = 0;
    endtask

    task automatic pop_chk(input logic [7:0] a, input logic [31:0] d,
                           input logic l);
        chk("pop_valid", bus.msg_valid, 1);
        chk("pop_addr", bus.msg_addr, a);
        chk("pop_data", bus.msg_data, d);
        chk("pop_last", bus.msg_last, l);
        bus.msg_pop = 1;
        cyc();
        bus.msg_pop = 0;
    endtask

    task automatic long_msg();
        int r, f, d0;
        d0 = drop_cnt;
        for (int i = 0; i < 10; i++) begin
            send(8'(8'h60 + i), 32'(100 + i), i != 9, r, f);
            if (i == 7) chk("ovf_w8", bus.overflow, 0);
            if (i == 8) chk("ovf_w9", bus.overflow, 1);
        end
        cyc();
        chk("long_drop", 64'(drop_cnt - d0), 1);
        chk("long_valid", bus.msg_valid, 0);
        chk("long_ovf", bus.overflow, 1);
    endtask

    initial begin
        int r, f, d0;
        bus.rx_addr = 0;
        bus.rx_data = 0;
        bus.rx_req  = 0;
        bus.rx_pend = 0;
        bus.rx_fail = 0;
        bus.msg_pop = 0;
        bus.ovf_clr = 0;
        repeat (3) cyc();
        RESETn = 1;
        cyc();
        chk("rst_ack", bus.rx_ack, 0);
        chk("rst_valid", bus.msg_valid, 0);
        chk("rst_drop", bus.msg_drop, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk_en = 1;

        // single word
        send(8'hab, 32'hdeadbeef, 0, r, f);
        chk("rise_lat", r, 3);
        chk("fall_lat", f, 3);
        pop_chk(8'hab, 32'hdeadbeef, 1);
        chk("single_empty", bus.msg_valid, 0);

        // three-word message
        send(8'h11, 32'h1000, 1, r, f);
        chk("m3_v1", bus.msg_valid, 0);
        send(8'h12, 32'h1001, 1, r, f);
        chk("m3_v2", bus.msg_valid, 0);
        send(8'h13, 32'h1002, 0, r, f);
        chk("m3_v3", bus.msg_valid, 1);
        pop_chk(8'h11, 32'h1000, 0);
        pop_chk(8'h12, 32'h1001, 0);
        pop_chk(8'h13, 32'h1002, 1);
        chk("m3_empty", bus.msg_valid, 0);

        // abort mid-message
        send(8'h21, 32'h2000, 1, r, f);
        send(8'h22, 32'h2001, 1, r, f);
        d0 = drop_cnt;
        bus.rx_fail = 1;
        busy = 1;
        wait_ack(1, r);
        chk("fail_lat", r, 3);
        bus.rx_fail = 0;
        wait_ack(0, f);
        busy = 0;
        repeat (2) cyc();
        chk("fail_drop", 64'(drop_cnt - d0), 1);
        chk("fail_valid", bus.msg_valid, 0);
        bus.msg_pop = 1;
        cyc();
        bus.msg_pop = 0;
        send(8'h31, 32'h3000, 0, r, f);
        pop_chk(8'h31, 32'h3000, 1);

        // buffer full of committed words stalls the handshake
        for (int i = 0; i < D; i++) send(8'(8'h40 + i), 32'(i), 0, r, f);
        bus.rx_addr = 8'h50;
        bus.rx_data = 32'h55;
        bus.rx_pend = 0;
        bus.rx_req  = 1;
        busy = 1;
        repeat (12) cyc();
        chk("stall_ack", bus.rx_ack, 0);
        bus.msg_pop = 1;
        cyc();
        bus.msg_pop = 0;
        wait_ack(1, r);
        bus.rx_req = 0;
        wait_ack(0, f);
        busy = 0;
        for (int i = 1; i < D; i++) pop_chk(8'(8'h40 + i), 32'(i), 1);
        pop_chk(8'h50, 32'h55, 1);
        chk("full_empty", bus.msg_valid, 0);

        // oversize message
        long_msg();

        // reset in the middle of an acknowledged handshake
        bus.rx_addr = 8'h70;
        bus.rx_data = 32'h7000;
        bus.rx_pend = 0;
        bus.rx_req  = 1;
        busy = 1;
        wait_ack(1, r);
        RESETn = 0;
        #1;
        chk("rstm_ack", bus.rx_ack, 0);
        chk("rstm_valid", bus.msg_valid, 0);
        chk("rstm_drop", bus.msg_drop, 0);
        chk("rstm_ovf", bus.overflow, 0);
        model_reset();
        bus.rx_req = 0;
        busy = 0;
        repeat (3) cyc();
        RESETn = 1;
        cyc();
        send(8'h71, 32'h7100, 0, r, f);
        chk("post_rst_lat", r, 3);
        pop_chk(8'h71, 32'h7100, 1);

        // overflow again, then clear it
        long_msg();
        bus.ovf_clr = 1;
        cyc();
        bus.ovf_clr = 0;
        chk("ovf_clr", bus.overflow, 0);
        repeat (2) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
